// File: rtl/glay_kernel_setup_scheduler.sv
// glay_kernel_setup_scheduler
// Walks a descriptor (base address, byte length) and issues one cache-line
// setup request per line, with at most MAX_OUTSTANDING requests in flight.
// Optional build macro GLAY_SETUP_SCHED_PERF_EN adds stall_cycles_out, a
// saturating count of cycles in which a request was offered but not taken.
module glay_kernel_setup_scheduler #(
    parameter int ADDR_W          = 64,
    parameter int LINE_BYTES      = 64,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [31:0]       total_bytes_in,
    output logic              req_valid_out,
    input  logic              req_ready_in,
    output logic [ADDR_W-1:0] req_addr_out,
    output logic [7:0]        req_id_out,
    input  logic              resp_valid_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out
`ifdef GLAY_SETUP_SCHED_PERF_EN
    ,
    output logic [31:0]       stall_cycles_out
`endif
);

    localparam int LB_SH = $clog2(LINE_BYTES);
    localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [31:0]       total_q;
    logic [26:0]       lines_rem;
    logic [OW-1:0]     outst;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        id_q;
    logic              err_q;

    logic [32:0]       lines_sum;
    logic [26:0]       lines_calc;
    logic              fire;
    logic              resp_ok;
    logic              start_acc;

    // Line count rounded up; 33-bit sum so a length near 2^32 cannot overflow.
    assign lines_sum  = {1'b0, total_q} + 33'(LINE_BYTES - 1);
    assign lines_calc = 27'(lines_sum >> LB_SH);

    assign start_acc     = (state == S_IDLE) && start_in;
    assign req_valid_out = (state == S_REQ) && (lines_rem != 27'd0) &&
                           (outst < OW'(MAX_OUTSTANDING));
    assign fire          = req_valid_out && req_ready_in;
    assign resp_ok       = resp_valid_in && (outst != '0);

    assign req_addr_out = addr_q;
    assign req_id_out   = id_q;
    assign busy_out     = (state == S_SETUP) || (state == S_REQ) || (state == S_DRAIN);
    assign done_out     = (state == S_DONE);
    assign err_out      = err_q;

    // Sequencer: descriptor latch, line walk and state transitions.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= S_IDLE;
            total_q   <= '0;
            lines_rem <= '0;
            addr_q    <= '0;
            id_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        addr_q  <= base_addr_in & ~ADDR_W'(LINE_BYTES - 1);
                        total_q <= total_bytes_in;
                        id_q    <= '0;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    lines_rem <= lines_calc;
                    state     <= (lines_calc == 27'd0) ? S_DONE : S_REQ;
                end
                S_REQ: begin
                    if (fire) begin
                        addr_q    <= addr_q + ADDR_W'(LINE_BYTES);
                        id_q      <= id_q + 8'd1;
                        lines_rem <= lines_rem - 27'd1;
                        if (lines_rem == 27'd1) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (outst == '0) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // In-flight tracking; a response with nothing outstanding is flagged, not counted.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            outst <= '0;
            err_q <= 1'b0;
        end else begin
            case ({fire, resp_ok})
                2'b10:   outst <= outst + OW'(1);
                2'b01:   outst <= outst - OW'(1);
                default: outst <= outst;
            endcase
            if (start_acc) err_q <= 1'b0;
            if (resp_valid_in && (outst == '0)) err_q <= 1'b1;
        end
    end

`ifdef GLAY_SETUP_SCHED_PERF_EN
    logic [31:0] stall_q;
    assign stall_cycles_out = stall_q;

    // Backpressure counter, saturating, restarted with each accepted descriptor.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (req_valid_out && !req_ready_in && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_glay_kernel_setup_scheduler.sv
// Scoreboard bench for glay_kernel_setup_scheduler: expected requests are
// queued at start; a negedge monitor pops and compares on every fire.
module tb_glay_kernel_setup_scheduler;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic [63:0] base_addr_in = '0;
    logic [31:0] total_bytes_in = '0;
    logic        req_valid_out;
    logic        req_ready_in = 1'b0;
    logic [63:0] req_addr_out;
    logic [7:0]  req_id_out;
    logic        resp_valid_in;
    logic        busy_out;
    logic        done_out;
    logic        err_out;
`ifdef GLAY_SETUP_SCHED_PERF_EN
    logic [31:0] stall_cycles_out;
`endif

    logic resp_auto = 1'b0;
    logic resp_man = 1'b0;
    logic auto_en = 1'b0;
    assign resp_valid_in = resp_auto | resp_man;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  id;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int fire_cnt = 0;
    int done_cnt = 0;
    int stall_cnt = 0;

    glay_kernel_setup_scheduler #(.ADDR_W(64), .LINE_BYTES(64), .MAX_OUTSTANDING(16)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start_in(start_in),
        .base_addr_in(base_addr_in), .total_bytes_in(total_bytes_in),
        .req_valid_out(req_valid_out), .req_ready_in(req_ready_in),
        .req_addr_out(req_addr_out), .req_id_out(req_id_out),
        .resp_valid_in(resp_valid_in), .busy_out(busy_out),
        .done_out(done_out), .err_out(err_out)
`ifdef GLAY_SETUP_SCHED_PERF_EN
        , .stall_cycles_out(stall_cycles_out)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic push_run(input logic [63:0] base, input int unsigned total);
        logic [63:0] a;
        int unsigned n;
        a = base & ~64'd63;
        n = (total + 63) / 64;
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back('{addr: a, id: 8'(i)});
            a = a + 64'd64;
        end
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(req_valid_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_done", 64'(done_out), 64'd0);
        check("rst_err", 64'(err_out), 64'd0);
        check("rst_addr", req_addr_out, 64'd0);
        check("rst_id", 64'(req_id_out), 64'd0);
        exp_q.delete();
        resp_man = 1'b0;
        start_in = 1'b0;
        cycles(2);
        ap_rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic pulse_start(input logic [63:0] base, input logic [31:0] total);
        base_addr_in   = base;
        total_bytes_in = total;
        start_in       = 1'b1;
        cycles(1);
        start_in       = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            cycles(1);
            n++;
        end
        check(name, 64'(done_cnt - d0), 64'd1);
        cycles(2);
    endtask

    // Monitor: scoreboard pops on fire, stability while stalled, event counters.
    initial begin
        logic        prev_stall;
        logic [63:0] prev_addr;
        logic [7:0]  prev_id;
        exp_t        e;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_id    = '0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (done_out) done_cnt++;
                if (req_valid_out) check("valid_implies_busy", 64'(busy_out), 64'd1);
                if (prev_stall) begin
                    check("stall_hold_valid", 64'(req_valid_out), 64'd1);
                    check("stall_hold_addr", req_addr_out, prev_addr);
                    check("stall_hold_id", 64'(req_id_out), 64'(prev_id));
                end
                if (req_valid_out && req_ready_in) begin
                    fire_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_req actual=%0h expected=none", req_addr_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("req_addr", req_addr_out, e.addr);
                        check("req_id", 64'(req_id_out), 64'(e.id));
                    end
                end
                if (req_valid_out && !req_ready_in) stall_cnt++;
                prev_stall = req_valid_out && !req_ready_in;
                prev_addr  = req_addr_out;
                prev_id    = req_id_out;
            end
        end
    end

    // Responder: one response three cycles after each fire when enabled.
    initial begin
        logic [2:0] sh;
        sh = '0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                sh        = '0;
                resp_auto = 1'b0;
            end else begin
                resp_auto = auto_en && sh[2];
                sh = {sh[1:0], req_valid_out && req_ready_in};
            end
        end
    end

    initial begin
        int f0, d0, s0;

        // Reset state, then basic run: 200 bytes from an unaligned base.
        do_reset();
        auto_en = 1'b1;
        req_ready_in = 1'b1;
        exp_q.push_back('{addr: 64'h1000_0000, id: 8'd0});
        exp_q.push_back('{addr: 64'h1000_0040, id: 8'd1});
        exp_q.push_back('{addr: 64'h1000_0080, id: 8'd2});
        exp_q.push_back('{addr: 64'h1000_00C0, id: 8'd3});
        f0 = fire_cnt; d0 = done_cnt;
        pulse_start(64'h1000_0010, 32'd200);
        check("setup_busy", 64'(busy_out), 64'd1);
        check("setup_valid", 64'(req_valid_out), 64'd0);
        cycles(1);
        check("first_valid_2cyc", 64'(req_valid_out), 64'd1);
        check("first_addr", req_addr_out, 64'h1000_0000);
        wait_done(d0, 60, "basic_done");
        check("basic_fires", 64'(fire_cnt - f0), 64'd4);
        check("basic_q_empty", 64'(exp_q.size()), 64'd0);
        check("basic_err", 64'(err_out), 64'd0);
        check("basic_idle", 64'(busy_out), 64'd0);

        // Zero-length descriptor.
        do_reset();
        f0 = fire_cnt;
        pulse_start(64'h0, 32'd0);
        check("zero_busy", 64'(busy_out), 64'd1);
        check("zero_done_early", 64'(done_out), 64'd0);
        cycles(1);
        check("zero_done", 64'(done_out), 64'd1);
        check("zero_busy_off", 64'(busy_out), 64'd0);
        cycles(1);
        check("zero_done_pulse", 64'(done_out), 64'd0);
        check("zero_fires", 64'(fire_cnt - f0), 64'd0);

        // In-flight cap with responses withheld, then coincident fire+response.
        do_reset();
        auto_en = 1'b0;
        req_ready_in = 1'b1;
        push_run(64'h0, 32'd2560);
        f0 = fire_cnt;
        pulse_start(64'h0, 32'd2560);
        cycles(30);
        check("cap_fires", 64'(fire_cnt - f0), 64'd16);
        check("cap_valid_low", 64'(req_valid_out), 64'd0);
        resp_man = 1'b1;
        cycles(1);
        resp_man = 1'b0;
        cycles(10);
        check("cap_one_more", 64'(fire_cnt - f0), 64'd17);
        check("cap_valid_low2", 64'(req_valid_out), 64'd0);
        req_ready_in = 1'b0;
        resp_man = 1'b1;
        cycles(1);
        resp_man = 1'b0;
        cycles(1);
        check("coin_pre_valid", 64'(req_valid_out), 64'd1);
        req_ready_in = 1'b1;
        resp_man = 1'b1;
        cycles(1);
        req_ready_in = 1'b0;
        resp_man = 1'b0;
        check("coin_fires", 64'(fire_cnt - f0), 64'd18);
        check("coin_valid_kept", 64'(req_valid_out), 64'd1);
        req_ready_in = 1'b1;
        cycles(1);
        req_ready_in = 1'b0;
        check("coin_fill_fires", 64'(fire_cnt - f0), 64'd19);
        check("coin_full_valid", 64'(req_valid_out), 64'd0);
        check("cap_err", 64'(err_out), 64'd0);

        // Random backpressure with an address that wraps past 2^64.
        do_reset();
        auto_en = 1'b1;
        push_run(64'hFFFF_FFFF_FFFF_FF90, 32'd640);
        f0 = fire_cnt; d0 = done_cnt; s0 = stall_cnt;
        pulse_start(64'hFFFF_FFFF_FFFF_FF90, 32'd640);
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
            req_ready_in = 1'($urandom_range(0, 1));
            cycles(1);
        end
        req_ready_in = 1'b1;
        wait_done(d0, 40, "rand_done");
        check("rand_fires", 64'(fire_cnt - f0), 64'd10);
        check("rand_q_empty", 64'(exp_q.size()), 64'd0);
        check("rand_err", 64'(err_out), 64'd0);
`ifdef GLAY_SETUP_SCHED_PERF_EN
        check("stall_count", 64'(stall_cycles_out), 64'(stall_cnt - s0));
`endif

        // Reset mid-run, then a fresh run, then an unexpected response while idle.
        do_reset();
        req_ready_in = 1'b1;
        push_run(64'h0, 32'd1280);
        d0 = done_cnt;
        pulse_start(64'h0, 32'd1280);
        cycles(6);
        check("midrun_busy", 64'(busy_out), 64'd1);
        do_reset();
        check("abandon_no_done", 64'(done_cnt - d0), 64'd0);
        push_run(64'h40, 32'd128);
        f0 = fire_cnt; d0 = done_cnt;
        pulse_start(64'h40, 32'd128);
        wait_done(d0, 40, "rerun_done");
        check("rerun_fires", 64'(fire_cnt - f0), 64'd2);
        check("rerun_q_empty", 64'(exp_q.size()), 64'd0);
        check("rerun_err", 64'(err_out), 64'd0);
        resp_man = 1'b1;
        cycles(1);
        resp_man = 1'b0;
        check("idle_resp_err", 64'(err_out), 64'd1);
        cycles(2);
        check("err_sticky", 64'(err_out), 64'd1);
        pulse_start(64'h0, 32'd0);
        check("err_clear_on_start", 64'(err_out), 64'd0);
        cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
